// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Shared VGA timing defaults, counter geometry and FSM state
//               encodings for the sync receiver and generator-side logic.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int c_hTotalDefault     = 800;
    localparam int c_hSyncLenDefault   = 96;
    localparam int c_vTotalDefault     = 525;
    localparam int c_vSyncLenDefault   = 6;
    localparam int c_lockFramesDefault = 2;

    localparam int c_cntWidth = 12;
    localparam logic [c_cntWidth-1:0] c_cntMax = '1;

    localparam logic [1:0] c_stSearch = 2'd0;
    localparam logic [1:0] c_stTrack  = 2'd1;
    localparam logic [1:0] c_stLocked = 2'd2;

    // Position counters stop at all-ones instead of wrapping.
    function automatic logic [c_cntWidth-1:0] satInc(input logic [c_cntWidth-1:0] value);
        return (value == c_cntMax) ? value : value + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_detect
// Description : Two-flop synchronizer followed by a registered edge detector.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_detect (
    input  logic clk,
    input  logic rstN,
    input  logic syncIn,
    output logic rise,
    output logic fall,
    output logic level
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_rise;
    logic r_fall;

    // Input edge reaches rise/fall after the third clock edge.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_meta <= syncIn;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_rise <= r_sync & ~r_prev;
            r_fall <= ~r_sync & r_prev;
        end
    end

    assign rise  = r_rise;
    assign fall  = r_fall;
    assign level = r_prev;

endmodule
`default_nettype wire

// File: rtl/sync_receiver.sv
`default_nettype none
// ============================================================================
// Module      : sync_receiver
// Description : Recovers pixel/line position from external h/v sync and
//               tracks timing lock through a SEARCH/TRACK/LOCKED FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_receiver
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL     = c_hTotalDefault,
    parameter int H_SYNC_LEN  = c_hSyncLenDefault,
    parameter int V_TOTAL     = c_vTotalDefault,
    parameter int V_SYNC_LEN  = c_vSyncLenDefault,
    parameter int LOCK_FRAMES = c_lockFramesDefault
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  horzSyncIn,
    input  logic                  vertSyncIn,
    output logic [c_cntWidth-1:0] horzCount,
    output logic [c_cntWidth-1:0] vertCount,
    output logic                  locked,
    output logic                  frameStart,
    output logic                  syncError
);

    localparam int c_goodW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

    localparam logic [c_cntWidth-1:0] c_hLast     = c_cntWidth'(H_TOTAL - 1);
    localparam logic [c_cntWidth-1:0] c_hSyncLast = c_cntWidth'(H_SYNC_LEN - 1);
    localparam logic [c_cntWidth-1:0] c_vLast     = c_cntWidth'(V_TOTAL - 1);
    localparam logic [c_cntWidth-1:0] c_vSyncLast = c_cntWidth'(V_SYNC_LEN - 1);
    localparam logic [c_goodW-1:0]    c_lockGoal  = c_goodW'(LOCK_FRAMES);

    logic                  w_hRise;
    logic                  w_hFall;
    logic                  w_vRise;
    logic                  w_vFall;
    logic [1:0]            w_unusedLevels;

    logic [c_cntWidth-1:0] r_horzCount;
    logic [c_cntWidth-1:0] r_vertCount;
    logic [1:0]            r_state;
    logic [c_goodW-1:0]    r_goodCnt;
    logic                  r_hExempt;
    logic                  r_syncError;

    logic                  w_lineErr;
    logic                  w_hWidthErr;
    logic                  w_frameErr;
    logic                  w_vWidthErr;
    logic                  w_timeoutErr;
    logic                  w_checkFail;
    logic [c_goodW-1:0]    w_goodNext;

    sync_edge_detect u_horzSync (
        .clk    (clk),
        .rstN   (rstN),
        .syncIn (horzSyncIn),
        .rise   (w_hRise),
        .fall   (w_hFall),
        .level  (w_unusedLevels[0])
    );

    sync_edge_detect u_vertSync (
        .clk    (clk),
        .rstN   (rstN),
        .syncIn (vertSyncIn),
        .rise   (w_vRise),
        .fall   (w_vFall),
        .level  (w_unusedLevels[1])
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_horzCount <= '0;
            r_vertCount <= '0;
        end else begin
            r_horzCount <= w_hRise ? '0 : satInc(r_horzCount);
            if (w_vRise) begin
                r_vertCount <= '0;
            end else if (w_hRise) begin
                r_vertCount <= satInc(r_vertCount);
            end
        end
    end

    // A missing hsync shows up as a saturated pixel counter.
    always_comb begin
        w_lineErr    = w_hRise && !r_hExempt && (r_horzCount != c_hLast);
        w_hWidthErr  = w_hFall && (r_horzCount != c_hSyncLast);
        w_frameErr   = w_vRise && (r_state != c_stSearch) && (r_vertCount != c_vLast);
        w_vWidthErr  = w_vFall && (r_vertCount != c_vSyncLast);
        w_timeoutErr = (r_horzCount == c_cntMax);
        w_checkFail  = w_lineErr | w_hWidthErr | w_frameErr | w_vWidthErr | w_timeoutErr;
        w_goodNext   = r_goodCnt + c_goodW'(1);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state     <= c_stSearch;
            r_goodCnt   <= '0;
            r_hExempt   <= 1'b1;
            r_syncError <= 1'b0;
        end else begin
            r_syncError <= 1'b0;
            if (w_checkFail && (r_state != c_stSearch)) begin
                r_state     <= c_stSearch;
                r_goodCnt   <= '0;
                r_hExempt   <= 1'b1;
                r_syncError <= 1'b1;
            end else begin
                if (w_hRise) begin
                    r_hExempt <= 1'b0;
                end
                case (r_state)
                    c_stSearch: begin
                        if (w_vRise) begin
                            r_state   <= c_stTrack;
                            r_goodCnt <= '0;
                        end
                    end
                    c_stTrack: begin
                        if (w_vRise) begin
                            r_goodCnt <= w_goodNext;
                            if (w_goodNext >= c_lockGoal) begin
                                r_state <= c_stLocked;
                            end
                        end
                    end
                    c_stLocked: begin
                        r_state <= c_stLocked;
                    end
                    default: begin
                        r_state <= c_stSearch;
                    end
                endcase
            end
        end
    end

    assign horzCount  = r_horzCount;
    assign vertCount  = r_vertCount;
    assign locked     = (r_state == c_stLocked);
    assign frameStart = w_vRise;
    assign syncError  = r_syncError;

endmodule
`default_nettype wire
